// File: rtl/mem_unit.sv
// rtl/mem_unit.sv - byte-addressed big-endian data memory with load/store FSM and configurable latency
module mem_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 256,
    parameter int LATENCY    = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  sig_MemReq,
    input  logic                  sig_MemWrite,
    input  logic [1:0]            sig_MemSize,
    input  logic                  sig_MemSigned,
    input  logic [ADDR_WIDTH-1:0] adr,
    input  logic [31:0]           wd,
    output logic [31:0]           rd,
    output logic                  sig_MemReady,
    output logic                  sig_MemBusy,
    output logic                  sig_MemErr
);

    localparam int                  IDX_W     = $clog2(DEPTH);
    localparam logic [3:0]          LAT_M1    = 4'(LATENCY - 1);
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state;
    logic [3:0]       cnt;

    // Request captured at the accept edge; later input changes cannot disturb it.
    logic [IDX_W-1:0] cap_idx;
    logic [31:0]      cap_wd;
    logic [1:0]       cap_size;
    logic             cap_write;
    logic             cap_signed;

    // Byte storage is deliberately outside the reset domain so reset leaves contents intact.
    logic [7:0]       ram [0:DEPTH-1];

    logic             req_err;
    logic             access_now;
    logic             ram_we;
    logic [IDX_W-1:0] idx1;
    logic [IDX_W-1:0] idx2;
    logic [IDX_W-1:0] idx3;
    logic [7:0]       b0;
    logic [7:0]       b1;
    logic [7:0]       b2;
    logic [7:0]       b3;
    logic [31:0]      load_val;

    // Classify the incoming request: reserved size, misalignment or out-of-range address.
    always_comb begin
        req_err = 1'b0;
        if (sig_MemSize == SIZE_RSVD)
            req_err = 1'b1;
        if (sig_MemSize == SIZE_HALF && adr[0])
            req_err = 1'b1;
        if (sig_MemSize == SIZE_WORD && adr[1:0] != 2'b00)
            req_err = 1'b1;
        if ({1'b0, adr} >= DEPTH_LIM)
            req_err = 1'b1;
    end

    // The array access happens on the BUSY edge where the countdown has expired.
    assign access_now = (state == BUSY) && (cnt == 4'd0);
    assign ram_we     = access_now && cap_write;

    // Aligned accesses never cross a 4-byte group, so the low two index bits select lanes.
    assign idx1 = {cap_idx[IDX_W-1:2], 2'b01} | {{(IDX_W-1){1'b0}}, cap_idx[1]} << 1;
    assign idx2 = {cap_idx[IDX_W-1:2], 2'b10};
    assign idx3 = {cap_idx[IDX_W-1:2], 2'b11};

    assign b0 = ram[cap_idx];
    assign b1 = ram[idx1];
    assign b2 = ram[idx2];
    assign b3 = ram[idx3];

    // Big-endian load assembly with optional sign extension for byte and half.
    always_comb begin
        load_val = 32'd0;
        case (cap_size)
            SIZE_BYTE: load_val = cap_signed ? {{24{b0[7]}}, b0} : {24'd0, b0};
            SIZE_HALF: load_val = cap_signed ? {{16{b0[7]}}, b0, b1} : {16'd0, b0, b1};
            default:   load_val = {b0, b1, b2, b3};
        endcase
    end

    // Big-endian store of the low 1, 2 or 4 bytes of the captured store data.
    always_ff @(posedge clock) begin
        if (ram_we) begin
            case (cap_size)
                SIZE_BYTE: begin
                    ram[cap_idx] <= cap_wd[7:0];
                end
                SIZE_HALF: begin
                    ram[cap_idx] <= cap_wd[15:8];
                    ram[idx1]    <= cap_wd[7:0];
                end
                default: begin
                    ram[cap_idx] <= cap_wd[31:24];
                    ram[idx1]    <= cap_wd[23:16];
                    ram[idx2]    <= cap_wd[15:8];
                    ram[idx3]    <= cap_wd[7:0];
                end
            endcase
        end
    end

    // Control FSM: capture in IDLE, count down in BUSY, one-cycle completion pulse in DONE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            cap_idx      <= '0;
            cap_wd       <= 32'd0;
            cap_size     <= 2'b00;
            cap_write    <= 1'b0;
            cap_signed   <= 1'b0;
            rd           <= 32'd0;
            sig_MemReady <= 1'b0;
            sig_MemBusy  <= 1'b0;
            sig_MemErr   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sig_MemReq) begin
                        cap_idx     <= adr[IDX_W-1:0];
                        cap_wd      <= wd;
                        cap_size    <= sig_MemSize;
                        cap_write   <= sig_MemWrite;
                        cap_signed  <= sig_MemSigned;
                        sig_MemBusy <= 1'b1;
                        if (req_err) begin
                            // Rejected requests skip the wait and never touch the array.
                            state        <= DONE;
                            cnt          <= 4'd0;
                            rd           <= 32'd0;
                            sig_MemReady <= 1'b1;
                            sig_MemErr   <= 1'b1;
                        end else begin
                            state <= BUSY;
                            cnt   <= LAT_M1;
                        end
                    end
                end
                BUSY: begin
                    if (cnt == 4'd0) begin
                        state        <= DONE;
                        sig_MemReady <= 1'b1;
                        sig_MemErr   <= 1'b0;
                        // Stores leave rd holding its previous value.
                        if (!cap_write)
                            rd <= load_val;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    state        <= IDLE;
                    sig_MemReady <= 1'b0;
                    sig_MemErr   <= 1'b0;
                    sig_MemBusy  <= 1'b0;
                end
                default: begin
                    state        <= IDLE;
                    cnt          <= 4'd0;
                    sig_MemReady <= 1'b0;
                    sig_MemErr   <= 1'b0;
                    sig_MemBusy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_unit.sv
// tb/tb_mem_unit.sv - directed self-checking bench for mem_unit
module tb_mem_unit;

    localparam int AW  = 32;
    localparam int DEP = 64;
    localparam int LAT = 2;

    logic          clock;
    logic          reset;
    logic          sig_MemReq;
    logic          sig_MemWrite;
    logic [1:0]    sig_MemSize;
    logic          sig_MemSigned;
    logic [AW-1:0] adr;
    logic [31:0]   wd;
    logic [31:0]   rd;
    logic          sig_MemReady;
    logic          sig_MemBusy;
    logic          sig_MemErr;

    int tests = 0;
    int fails = 0;

    mem_unit #(.ADDR_WIDTH(AW), .DEPTH(DEP), .LATENCY(LAT)) dut (
        .clock         (clock),
        .reset         (reset),
        .sig_MemReq    (sig_MemReq),
        .sig_MemWrite  (sig_MemWrite),
        .sig_MemSize   (sig_MemSize),
        .sig_MemSigned (sig_MemSigned),
        .adr           (adr),
        .wd            (wd),
        .rd            (rd),
        .sig_MemReady  (sig_MemReady),
        .sig_MemBusy   (sig_MemBusy),
        .sig_MemErr    (sig_MemErr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic mem_req(input logic wr, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] d,
                           output int lat, output logic [31:0] rdo,
                           output logic erro, output logic busy0);
        sig_MemReq    = 1'b1;
        sig_MemWrite  = wr;
        sig_MemSize   = sz;
        sig_MemSigned = sg;
        adr           = a;
        wd            = d;
        @(negedge clock);
        busy0         = sig_MemBusy;
        sig_MemReq    = 1'b0;
        adr           = $urandom();
        wd            = $urandom();
        sig_MemSize   = 2'($urandom());
        sig_MemWrite  = 1'($urandom());
        sig_MemSigned = 1'($urandom());
        lat = 0;
        while (!sig_MemReady && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        rdo  = rd;
        erro = sig_MemErr;
        @(negedge clock);
    endtask

    int          lat;
    logic [31:0] rdv;
    logic        errv;
    logic        bsy;
    logic [31:0] b2b_val [5];

    initial begin
        reset         = 1'b1;
        sig_MemReq    = 1'b0;
        sig_MemWrite  = 1'b0;
        sig_MemSize   = 2'b00;
        sig_MemSigned = 1'b0;
        adr           = '0;
        wd            = 32'd0;
        repeat (2) @(negedge clock);
        check("rst_rd",    rd,           32'd0);
        check("rst_ready", sig_MemReady, 32'd0);
        check("rst_busy",  sig_MemBusy,  32'd0);
        check("rst_err",   sig_MemErr,   32'd0);

        // First request accepted at the first edge after reset release.
        reset = 1'b0;
        mem_req(1'b1, 2'b10, 1'b0, 32'd8, 32'h12345678, lat, rdv, errv, bsy);
        check("sw8_busy", bsy,  32'd1);
        check("sw8_lat",  lat,  LAT);
        check("sw8_err",  errv, 32'd0);

        mem_req(1'b0, 2'b10, 1'b0, 32'd8, 32'h0, lat, rdv, errv, bsy);
        check("lw8_lat", lat,  LAT);
        check("lw8_rd",  rdv,  32'h12345678);
        check("lw8_err", errv, 32'd0);

        // Only the low byte is stored; rd keeps the previous load result.
        mem_req(1'b1, 2'b00, 1'b1, 32'd9, 32'hABCDEF80, lat, rdv, errv, bsy);
        check("sb9_err",  errv, 32'd0);
        check("sb9_hold", rdv,  32'h12345678);

        mem_req(1'b0, 2'b00, 1'b1, 32'd9, 32'h0, lat, rdv, errv, bsy);
        check("lb9_signed", rdv, 32'hFFFFFF80);
        mem_req(1'b0, 2'b00, 1'b0, 32'd9, 32'h0, lat, rdv, errv, bsy);
        check("lbu9", rdv, 32'h00000080);
        mem_req(1'b0, 2'b01, 1'b1, 32'd8, 32'h0, lat, rdv, errv, bsy);
        check("lh8_signed", rdv, 32'h00001280);
        mem_req(1'b0, 2'b00, 1'b0, 32'd8, 32'h0, lat, rdv, errv, bsy);
        check("lbu8", rdv, 32'h00000012);
        mem_req(1'b0, 2'b10, 1'b1, 32'd8, 32'h0, lat, rdv, errv, bsy);
        check("lw8_after_sb", rdv, 32'h12805678);

        // Misaligned word load: immediate completion, error, rd cleared.
        mem_req(1'b0, 2'b10, 1'b0, 32'd6, 32'h0, lat, rdv, errv, bsy);
        check("lw6_lat", lat,  32'd0);
        check("lw6_err", errv, 32'd1);
        check("lw6_rd",  rdv,  32'd0);

        mem_req(1'b1, 2'b10, 1'b0, 32'd0, 32'h01020304, lat, rdv, errv, bsy);
        check("sw0_err", errv, 32'd0);
        mem_req(1'b1, 2'b01, 1'b0, 32'd3, 32'h0000BEEF, lat, rdv, errv, bsy);
        check("sh3_err", errv, 32'd1);
        check("sh3_lat", lat,  32'd0);
        mem_req(1'b0, 2'b10, 1'b0, 32'd0, 32'h0, lat, rdv, errv, bsy);
        check("lw0_unchanged", rdv, 32'h01020304);

        mem_req(1'b0, 2'b11, 1'b0, 32'd0, 32'h0, lat, rdv, errv, bsy);
        check("size11_err", errv, 32'd1);
        mem_req(1'b0, 2'b10, 1'b0, 32'd64, 32'h0, lat, rdv, errv, bsy);
        check("lw64_err", errv, 32'd1);
        check("lw64_lat", lat,  32'd0);
        mem_req(1'b1, 2'b00, 1'b0, 32'd63, 32'h0000005A, lat, rdv, errv, bsy);
        check("sb63_err", errv, 32'd0);
        mem_req(1'b0, 2'b00, 1'b0, 32'd63, 32'h0, lat, rdv, errv, bsy);
        check("lbu63", rdv, 32'h0000005A);

        mem_req(1'b1, 2'b10, 1'b0, 32'd12, 32'h5566F7E8, lat, rdv, errv, bsy);
        mem_req(1'b0, 2'b01, 1'b1, 32'd14, 32'h0, lat, rdv, errv, bsy);
        check("lh14_signed", rdv, 32'hFFFFF7E8);
        mem_req(1'b0, 2'b01, 1'b0, 32'd14, 32'h0, lat, rdv, errv, bsy);
        check("lhu14", rdv, 32'h0000F7E8);

        // Store aborted by reset one cycle after accept.
        sig_MemReq   = 1'b1;
        sig_MemWrite = 1'b1;
        sig_MemSize  = 2'b10;
        adr          = 32'd12;
        wd           = 32'hAABBCCDD;
        @(negedge clock);
        sig_MemReq = 1'b0;
        check("abort_busy_pre", sig_MemBusy, 32'd1);
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("abort_busy",  sig_MemBusy,  32'd0);
        check("abort_ready", sig_MemReady, 32'd0);
        check("abort_rd",    rd,           32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        mem_req(1'b0, 2'b10, 1'b0, 32'd12, 32'h0, lat, rdv, errv, bsy);
        check("abort_lw12", rdv, 32'h5566F7E8);

        // Back-to-back: request held high, address changes every cycle.
        for (int i = 0; i < 5; i++) begin
            b2b_val[i] = 32'hC0DE0000 + 32'(i);
            mem_req(1'b1, 2'b10, 1'b0, 32'(16 + 4 * i), b2b_val[i], lat, rdv, errv, bsy);
        end
        sig_MemReq    = 1'b1;
        sig_MemWrite  = 1'b0;
        sig_MemSize   = 2'b10;
        sig_MemSigned = 1'b0;
        for (int c = 0; c < 12; c++) begin
            adr = 32'(16 + 4 * (c % 5));
            @(negedge clock);
            check($sformatf("b2b_ready_%0d", c), sig_MemReady, (c % 4 == 2) ? 32'd1 : 32'd0);
            if (c % 4 == 2)
                check($sformatf("b2b_rd_%0d", c), rd, b2b_val[(c - 2) % 5]);
        end
        sig_MemReq = 1'b0;
        repeat (4) @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
